// File: rtl/drink_sequencer_if.sv
// Signal bundle between the drink sequencer and its surroundings.
// It carries the tick strobe, payment, selection and sensor inputs, plus the LED, status and debug outputs.
interface drink_sequencer_if;
    logic       tick;
    logic       pay_ok;
    logic [1:0] drink_sel;
    logic       cancel;
    logic       sensors_ok;
    logic       led_press;
    logic       led_aquec;
    logic       led_bebida_1;
    logic       led_bebida_2;
    logic       busy;
    logic       done;
    logic       refund;
    logic [2:0] state;

    modport master (
        output tick, pay_ok, drink_sel, cancel, sensors_ok,
        input  led_press, led_aquec, led_bebida_1, led_bebida_2,
               busy, done, refund, state
    );

    modport slave (
        input  tick, pay_ok, drink_sel, cancel, sensors_ok,
        output led_press, led_aquec, led_bebida_1, led_bebida_2,
               busy, done, refund, state
    );
endinterface

// File: rtl/drink_sequencer.sv
// Sequences one drink-preparation cycle: selection, pressurization, heating, dispensing, then completion or refund.
// A single tick counter times every phase, and all outputs are decoded from registered state.
module drink_sequencer #(
    parameter int T_SEL   = 15,
    parameter int T_PRESS = 2,
    parameter int T_HEAT  = 2,
    parameter int T_DISP  = 5,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    drink_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        SEL    = 3'b001,
        PRESS  = 3'b010,
        HEAT   = 3'b011,
        DISP   = 3'b100,
        DONE   = 3'b101,
        REFUND = 3'b110
    } state_t;

    localparam logic [CNT_W-1:0] SEL_LAST   = CNT_W'(T_SEL - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(T_PRESS - 1);
    localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(T_HEAT - 1);
    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(T_DISP - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       sel_reg, sel_next;
    logic             sel_valid;
    logic             timed;

    assign sel_valid = (bus.drink_sel == 2'b01) || (bus.drink_sel == 2'b10);
    assign timed     = (state_reg == SEL) || (state_reg == PRESS) ||
                       (state_reg == HEAT) || (state_reg == DISP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sel_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
        end
    end

    // Aborts are tested before expiry so that a cancel on the final tick wins.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (bus.pay_ok) state_next = SEL;
            end
            SEL: begin
                if (bus.cancel) begin
                    state_next = REFUND;
                end else if (sel_valid && bus.sensors_ok) begin
                    state_next = PRESS;
                    sel_next   = bus.drink_sel;
                end else if (bus.tick && cnt_reg == SEL_LAST) begin
                    state_next = REFUND;
                end
            end
            PRESS: begin
                if (bus.cancel || !bus.sensors_ok)             state_next = REFUND;
                else if (bus.tick && cnt_reg == PRESS_LAST)    state_next = HEAT;
            end
            HEAT: begin
                if (bus.cancel || !bus.sensors_ok)             state_next = REFUND;
                else if (bus.tick && cnt_reg == HEAT_LAST)     state_next = DISP;
            end
            DISP: begin
                if (bus.tick && cnt_reg == DISP_LAST)          state_next = DONE;
            end
            DONE, REFUND: begin
                state_next = IDLE;
                sel_next   = 2'b00;
            end
            default: begin
                state_next = IDLE;
                sel_next   = 2'b00;
            end
        endcase
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (state_next != state_reg)  cnt_next = '0;
        else if (bus.tick && timed)   cnt_next = cnt_reg + 1'b1;
    end

    assign bus.state        = state_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.led_press    = (state_reg == PRESS);
    assign bus.led_aquec    = (state_reg == HEAT);
    assign bus.led_bebida_1 = (state_reg == DISP) && (sel_reg == 2'b01);
    assign bus.led_bebida_2 = (state_reg == DISP) && (sel_reg == 2'b10);
    assign bus.done         = (state_reg == DONE);
    assign bus.refund       = (state_reg == REFUND);

endmodule

// File: tb/tb_drink_sequencer.sv
// Directed self-checking bench for drink_sequencer with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_drink_sequencer;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;
    int   done_cnt, refund_cnt, b1_cnt, b2_cnt, press_cnt, aquec_cnt;

    drink_sequencer_if bus ();

    drink_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counters for pulses and LEDs, so that "never asserts" can be checked.
    always @(posedge clk) begin
        if (bus.done)         done_cnt   <= done_cnt + 1;
        if (bus.refund)       refund_cnt <= refund_cnt + 1;
        if (bus.led_bebida_1) b1_cnt     <= b1_cnt + 1;
        if (bus.led_bebida_2) b2_cnt     <= b2_cnt + 1;
        if (bus.led_press)    press_cnt  <= press_cnt + 1;
        if (bus.led_aquec)    aquec_cnt  <= aquec_cnt + 1;
    end

    // Each tick arrives after 9 idle clocks and lasts one clock.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (9) @(negedge clk);
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    endtask

    // Called on a falling edge; returns on a falling edge with the FSM in PRESS.
    task automatic start_cycle(input logic [1:0] sel);
        bus.pay_ok     = 1'b1;
        bus.drink_sel  = sel;
        bus.sensors_ok = 1'b1;
        @(negedge clk);
        bus.pay_ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        tests_run++;
        if (bus.state !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.refund !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: state=%0d busy=%0b done=%0b refund=%0b, required 0/0/0/0",
                     bus.state, bus.busy, bus.done, bus.refund);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.state !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_idle: state=%0d required 0", bus.state);
        end
        $display("[TB] test_reset complete");
    endtask

    task automatic test_normal_cycle;
        int d0, r0, b20;
        d0 = done_cnt; r0 = refund_cnt; b20 = b2_cnt;
        start_cycle(2'b01);
        tests_run++;
        if (bus.state !== 3'b010 || bus.led_press !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_press_entry: state=%0d led_press=%0b busy=%0b, required 2/1/1",
                     bus.state, bus.led_press, bus.busy);
        end
        bus.drink_sel = 2'b10;
        tick_n(1);
        tests_run++;
        if (bus.state !== 3'b010) begin
            tests_failed++;
            $display("FAIL normal_press_hold: state=%0d required 2", bus.state);
        end
        tick_n(1);
        tests_run++;
        if (bus.state !== 3'b011 || bus.led_aquec !== 1'b1 || bus.led_press !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_heat: state=%0d led_aquec=%0b led_press=%0b, required 3/1/0",
                     bus.state, bus.led_aquec, bus.led_press);
        end
        tick_n(2);
        tests_run++;
        if (bus.state !== 3'b100 || bus.led_bebida_1 !== 1'b1 || bus.led_bebida_2 !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_disp_latched: state=%0d b1=%0b b2=%0b, required 4/1/0",
                     bus.state, bus.led_bebida_1, bus.led_bebida_2);
        end
        tick_n(4);
        tests_run++;
        if (bus.state !== 3'b100) begin
            tests_failed++;
            $display("FAIL normal_disp_hold: state=%0d required 4", bus.state);
        end
        tick_n(1);
        tests_run++;
        if (bus.state !== 3'b101 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL normal_done: state=%0d done=%0b, required 5/1", bus.state, bus.done);
        end
        @(negedge clk);
        tests_run++;
        if (bus.state !== 3'b000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL normal_return: state=%0d busy=%0b done=%0b, required 0/0/0",
                     bus.state, bus.busy, bus.done);
        end
        tests_run++;
        if (done_cnt - d0 !== 1 || refund_cnt - r0 !== 0 || b2_cnt - b20 !== 0) begin
            tests_failed++;
            $display("FAIL normal_pulses: done=%0d refund=%0d b2=%0d, required 1/0/0",
                     done_cnt - d0, refund_cnt - r0, b2_cnt - b20);
        end
        $display("[TB] test_normal_cycle complete");
    endtask

    task automatic test_sel_timeout;
        int r0, l0;
        r0 = refund_cnt;
        l0 = press_cnt + aquec_cnt + b1_cnt + b2_cnt;
        bus.pay_ok     = 1'b1;
        bus.drink_sel  = 2'b00;
        bus.sensors_ok = 1'b1;
        @(negedge clk);
        bus.pay_ok = 1'b0;
        tick_n(14);
        tests_run++;
        if (bus.state !== 3'b001) begin
            tests_failed++;
            $display("FAIL timeout_hold: state=%0d required 1", bus.state);
        end
        tick_n(1);
        tests_run++;
        if (bus.state !== 3'b110 || bus.refund !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_refund: state=%0d refund=%0b, required 6/1", bus.state, bus.refund);
        end
        @(negedge clk);
        tests_run++;
        if (bus.state !== 3'b000 || refund_cnt - r0 !== 1 ||
            press_cnt + aquec_cnt + b1_cnt + b2_cnt - l0 !== 0) begin
            tests_failed++;
            $display("FAIL timeout_after: state=%0d refunds=%0d led_cycles=%0d, required 0/1/0",
                     bus.state, refund_cnt - r0, press_cnt + aquec_cnt + b1_cnt + b2_cnt - l0);
        end
        $display("[TB] test_sel_timeout complete");
    endtask

    task automatic test_cancel_heat;
        int b20;
        b20 = b2_cnt;
        start_cycle(2'b10);
        tick_n(2);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        bus.tick   = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        bus.tick   = 1'b0;
        tests_run++;
        if (bus.state !== 3'b110 || bus.refund !== 1'b1 || bus.led_aquec !== 1'b0) begin
            tests_failed++;
            $display("FAIL cancel_heat: state=%0d refund=%0b led_aquec=%0b, required 6/1/0",
                     bus.state, bus.refund, bus.led_aquec);
        end
        @(negedge clk);
        tests_run++;
        if (bus.state !== 3'b000 || b2_cnt - b20 !== 0) begin
            tests_failed++;
            $display("FAIL cancel_heat_after: state=%0d b2_cycles=%0d, required 0/0",
                     bus.state, b2_cnt - b20);
        end
        $display("[TB] test_cancel_heat complete");
    endtask

    task automatic test_sensor_fault;
        start_cycle(2'b01);
        bus.sensors_ok = 1'b0;
        @(negedge clk);
        bus.sensors_ok = 1'b1;
        tests_run++;
        if (bus.state !== 3'b110 || bus.refund !== 1'b1) begin
            tests_failed++;
            $display("FAIL sensor_press: state=%0d refund=%0b, required 6/1", bus.state, bus.refund);
        end
        @(negedge clk);
        $display("[TB] test_sensor_fault complete");
    endtask

    task automatic test_disp_immunity;
        int r0;
        r0 = refund_cnt;
        start_cycle(2'b01);
        tick_n(4);
        bus.sensors_ok = 1'b0;
        bus.cancel     = 1'b1;
        tick_n(4);
        tests_run++;
        if (bus.state !== 3'b100 || bus.led_bebida_1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL disp_immune_hold: state=%0d b1=%0b, required 4/1", bus.state, bus.led_bebida_1);
        end
        tick_n(1);
        tests_run++;
        if (bus.state !== 3'b101 || bus.done !== 1'b1 || refund_cnt - r0 !== 0) begin
            tests_failed++;
            $display("FAIL disp_immune_done: state=%0d done=%0b refunds=%0d, required 5/1/0",
                     bus.state, bus.done, refund_cnt - r0);
        end
        bus.sensors_ok = 1'b1;
        bus.cancel     = 1'b0;
        @(negedge clk);
        $display("[TB] test_disp_immunity complete");
    endtask

    task automatic test_boundary;
        start_cycle(2'b01);
        tick_n(1);
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        bus.tick   = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        bus.tick   = 1'b0;
        tests_run++;
        if (bus.state !== 3'b110 || bus.led_aquec !== 1'b0) begin
            tests_failed++;
            $display("FAIL boundary_collision: state=%0d led_aquec=%0b, required 6/0", bus.state, bus.led_aquec);
        end
        @(negedge clk);
        $display("[TB] test_boundary complete");
    endtask

    task automatic test_async_reset;
        int d0;
        start_cycle(2'b01);
        tick_n(4);
        tests_run++;
        if (bus.state !== 3'b100) begin
            tests_failed++;
            $display("FAIL areset_pre: state=%0d required 4", bus.state);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (bus.state !== 3'b000 || bus.busy !== 1'b0 || bus.led_bebida_1 !== 1'b0 ||
            bus.done !== 1'b0 || bus.refund !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_immediate: state=%0d busy=%0b b1=%0b done=%0b refund=%0b, required all 0",
                     bus.state, bus.busy, bus.led_bebida_1, bus.done, bus.refund);
        end
        @(negedge clk);
        reset_n = 1'b1;
        d0 = done_cnt;
        start_cycle(2'b10);
        tick_n(4);
        tests_run++;
        if (bus.led_bebida_2 !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_rerun_disp: b2=%0b required 1", bus.led_bebida_2);
        end
        tick_n(5);
        @(negedge clk);
        tests_run++;
        if (bus.state !== 3'b000 || done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL areset_rerun_done: state=%0d done_pulses=%0d, required 0/1",
                     bus.state, done_cnt - d0);
        end
        $display("[TB] test_async_reset complete");
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        done_cnt       = 0;
        refund_cnt     = 0;
        b1_cnt         = 0;
        b2_cnt         = 0;
        press_cnt      = 0;
        aquec_cnt      = 0;
        bus.tick       = 1'b0;
        bus.pay_ok     = 1'b0;
        bus.drink_sel  = 2'b00;
        bus.cancel     = 1'b0;
        bus.sensors_ok = 1'b1;
        test_reset();
        test_normal_cycle();
        test_sel_timeout();
        test_cancel_heat();
        test_sensor_fault();
        test_disp_immunity();
        test_boundary();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/drink_sequencer.md
Name: drink_sequencer

Overview:
- Single-clock controller that sequences one drink-preparation cycle of the vending machine: selection window, pressurization, water heating, dispensing, completion or refund.
- Replaces the chained free-running timers with one tick-driven counter and an explicit FSM.
- Sits between payment verification / sensor logic (inputs) and the process LEDs / refund path (outputs).
- Timing base is a 1-cycle tick strobe from the clock divider; no derived clocks are used.

Parameters:
- T_SEL, 15, selection-window timeout in ticks
- T_PRESS, 2, pressurization duration in ticks
- T_HEAT, 2, heating duration in ticks
- T_DISP, 5, dispensing duration in ticks
- CNT_W, 4, tick counter width; must hold max(T_*) - 1

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- tick  in  1  one-clk-wide timing strobe, nominally 1 Hz
- pay_ok  in  1  payment verified (level); sampled only in IDLE
- drink_sel  in  2  drink choice: 01 = drink 1, 10 = drink 2; 00 and 11 are invalid/none
- cancel  in  1  user cancel (level, already debounced)
- sensors_ok  in  1  1 = water, cup and pressure sensors all good
- led_press  out  1  high in PRESS
- led_aquec  out  1  high in HEAT
- led_bebida_1  out  1  high in DISP when drink 1 is latched
- led_bebida_2  out  1  high in DISP when drink 2 is latched
- busy  out  1  high in every state except IDLE
- done  out  1  1-clk pulse on successful completion
- refund  out  1  1-clk pulse when money must be returned
- state  out  3  current FSM state encoding (debug/display)

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE (000); cnt = 0; latched selection = 00.
  - All outputs 0.
- State encodings: IDLE 000, SEL 001, PRESS 010, HEAT 011, DISP 100, DONE 101, REFUND 110. Code 111 is unused and recovers to IDLE on the next clk.
- Tick counter:
  - cnt clears to 0 on every state entry.
  - cnt increments on each tick while in a timed state.
  - A timed state of length T exits on the clk where tick = 1 and cnt = T-1.
  - Dwell is therefore T ticks, with up to one tick period of entry jitter.
  - Ticks in untimed states (IDLE, DONE, REFUND) are ignored.
- IDLE: pay_ok = 1 -> SEL.
- SEL (timed, T_SEL):
  - Priority 1: cancel = 1 -> REFUND.
  - Priority 2: valid drink_sel (01 or 10) with sensors_ok = 1 -> latch drink_sel, go to PRESS.
  - Valid drink_sel with sensors_ok = 0 -> stay in SEL; the timeout keeps running.
  - Timeout expiry -> REFUND.
- PRESS (timed, T_PRESS):
  - cancel = 1 or sensors_ok = 0 -> REFUND.
  - Expiry -> HEAT.
- HEAT (timed, T_HEAT): same abort rules as PRESS; expiry -> DISP.
- DISP (timed, T_DISP):
  - cancel and sensors_ok are ignored; dispensing is never interrupted.
  - Expiry -> DONE.
- DONE: done = 1 for exactly one clk, latched selection clears, then IDLE.
- REFUND: refund = 1 for exactly one clk, latched selection clears, then IDLE.
- Simultaneous events:
  - Abort beats expiry in the same clk: cancel on the final PRESS tick goes to REFUND, not HEAT.
  - In SEL, cancel beats a valid selection.
- drink_sel changes after the latch have no effect on the LEDs.
- pay_ok held high after DONE/REFUND starts a new cycle: IDLE -> SEL on the next clk. Upstream must clear pay_ok.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.

Test Plan:
- Normal cycle:
  - Stimulus: pay_ok pulse, drink_sel = 01, sensors_ok = 1, tick every 10 clk.
  - Response: led_press high 2 ticks, then led_aquec 2 ticks, then led_bebida_1 5 ticks; done pulses once; busy falls; refund never asserts.
- Selection timeout:
  - Stimulus: pay_ok, drink_sel held 00.
  - Response: after 15 ticks, one refund pulse; no process LED ever asserts; state returns to 000.
- Cancel mid-heat:
  - Stimulus: normal start with drink_sel = 10; cancel asserted during the 1st HEAT tick.
  - Response: next clk is REFUND, refund pulses, led_aquec drops, led_bebida_2 never asserts.
- Sensor fault / DISP immunity:
  - Stimulus A: sensors_ok = 0 during PRESS. Response A: REFUND.
  - Stimulus B: sensors_ok = 0 and cancel = 1 during DISP. Response B: DISP completes all 5 ticks and done pulses.
- Boundary collision:
  - Stimulus: cancel coincides with the tick at cnt = 1 in PRESS.
  - Response: REFUND, not HEAT.
- Async reset:
  - Stimulus: reset_n low mid-DISP, between clk edges.
  - Response: all outputs 0 and state = 000 immediately, without waiting for a clk edge; after release, a fresh pay_ok runs a full cycle.
